canvas_write_arbiter: RTL and testbench

Owns the single write port shared by the four canvas layer framebuffers feeding the compositor. Arbitrates between pen writes from the drawing front end and a built-in clear engine that sweeps a whole layer to `COLOR_NONE`. Also holds the per-layer visibility registers that drive the compositor's `canvasN_visible` inputs. Sits between the input/drawing logic and the canvas RAMs.

---
 rtl/canvas_write_arbiter.sv | 154 +++++++++++++++
 tb/tb_canvas_write_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/canvas_write_arbiter.sv
// Shared write port for the four canvas layers: pen writes vs. a full-layer clear engine, plus layer visibility.
// Optional CANVAS_CLEAR_HIDE_EN hides the layer being cleared from the compositor while the clear runs.
module canvas_write_arbiter #(
    parameter int unsigned WIDTH       = 640,
    parameter int unsigned HEIGHT      = 480,
    parameter int unsigned COLOR_WIDTH = 4,
    parameter logic [COLOR_WIDTH-1:0] COLOR_NONE = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       pen_req,
    input  logic [1:0]                 pen_layer,
    input  logic [$clog2(WIDTH)-1:0]   pen_x,
    input  logic [$clog2(HEIGHT)-1:0]  pen_y,
    input  logic [COLOR_WIDTH-1:0]     pen_color,
    output logic                       pen_ack,
    input  logic                       clear_req,
    input  logic [1:0]                 clear_layer,
    output logic                       clear_busy,
    input  logic                       toggle_vis,
    input  logic [1:0]                 toggle_layer,
    output logic [3:0]                 canvas_visible,
    output logic [3:0]                 wr_en,
    output logic [$clog2(WIDTH)-1:0]   wr_x,
    output logic [$clog2(HEIGHT)-1:0]  wr_y,
    output logic [COLOR_WIDTH-1:0]     wr_color
);

    localparam int unsigned XW = $clog2(WIDTH);
    localparam int unsigned YW = $clog2(HEIGHT);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic            rr_q, rr_d;
    logic [XW-1:0]   cx_q, cx_d;
    logic [YW-1:0]   cy_q, cy_d;
    logic [1:0]      layer_q, layer_d;
    logic [3:0]      vis_q;
    logic            pen_grant;
    logic            clear_grant;
    logic            contend;
    logic            last_x;
    logic            last_y;

    // State register: FSM, round-robin bit, sweep position and latched clear layer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            cx_q    <= '0;
            cy_q    <= '0;
            layer_q <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            layer_q <= layer_d;
        end
    end

    // Next state and grant decision.
    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        cx_d        = cx_q;
        cy_d        = cy_q;
        layer_d     = layer_q;
        pen_grant   = 1'b0;
        clear_grant = 1'b0;
        contend     = 1'b0;
        last_x      = (cx_q == XW'(WIDTH - 1));
        last_y      = (cy_q == YW'(HEIGHT - 1));

        case (state_q)
            IDLE: begin
                pen_grant = pen_req;
                if (clear_req) begin
                    state_d = CLEAR;
                    layer_d = clear_layer;
                    cx_d    = '0;
                    cy_d    = '0;
                end
            end
            CLEAR: begin
                // A pen aimed at the layer under clear never competes; it waits out the sweep.
                contend = pen_req && (pen_layer != layer_q);
                if (contend) begin
                    pen_grant   = ~rr_q;
                    clear_grant = rr_q;
                    rr_d        = ~rr_q;
                end else begin
                    clear_grant = 1'b1;
                end
                if (clear_grant) begin
                    if (last_x) begin
                        cx_d = '0;
                        if (last_y) begin
                            state_d = IDLE;
                        end else begin
                            cy_d = cy_q + 1'b1;
                        end
                    end else begin
                        cx_d = cx_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign pen_ack = pen_grant;

    // Registered write port, busy flag and visibility registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_en      <= 4'b0000;
            wr_x       <= '0;
            wr_y       <= '0;
            wr_color   <= COLOR_NONE;
            clear_busy <= 1'b0;
            vis_q      <= 4'b1111;
        end else begin
            clear_busy <= (state_d == CLEAR);
            if (toggle_vis) begin
                vis_q[toggle_layer] <= ~vis_q[toggle_layer];
            end
            if (pen_grant) begin
                wr_en    <= 4'b0001 << pen_layer;
                wr_x     <= pen_x;
                wr_y     <= pen_y;
                wr_color <= pen_color;
            end else if (clear_grant) begin
                wr_en    <= 4'b0001 << layer_q;
                wr_x     <= cx_q;
                wr_y     <= cy_q;
                wr_color <= COLOR_NONE;
            end else begin
                wr_en    <= 4'b0000;
            end
        end
    end

`ifdef CANVAS_CLEAR_HIDE_EN
    assign canvas_visible = vis_q & ~(clear_busy ? (4'b0001 << layer_q) : 4'b0000);
`else
    assign canvas_visible = vis_q;
`endif

endmodule

// File: tb/tb_canvas_write_arbiter.sv
// Bench for canvas_write_arbiter: directed table, clear/pen corner sequences, and random traffic vs. a reference model.
module tb_canvas_write_arbiter;

    localparam int W  = 8;
    localparam int H  = 8;
    localparam logic [3:0] NONE = 4'd0;
    localparam int RED = 4;

    logic       clk;
    logic       reset;
    logic       pen_req;
    logic [1:0] pen_layer;
    logic [2:0] pen_x;
    logic [2:0] pen_y;
    logic [3:0] pen_color;
    logic       pen_ack;
    logic       clear_req;
    logic [1:0] clear_layer;
    logic       clear_busy;
    logic       toggle_vis;
    logic [1:0] toggle_layer;
    logic [3:0] canvas_visible;
    logic [3:0] wr_en;
    logic [2:0] wr_x;
    logic [2:0] wr_y;
    logic [3:0] wr_color;

    canvas_write_arbiter #(
        .WIDTH(W), .HEIGHT(H), .COLOR_WIDTH(4), .COLOR_NONE(NONE)
    ) dut (
        .clk(clk), .reset(reset),
        .pen_req(pen_req), .pen_layer(pen_layer), .pen_x(pen_x), .pen_y(pen_y),
        .pen_color(pen_color), .pen_ack(pen_ack),
        .clear_req(clear_req), .clear_layer(clear_layer), .clear_busy(clear_busy),
        .toggle_vis(toggle_vis), .toggle_layer(toggle_layer),
        .canvas_visible(canvas_visible),
        .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_color(wr_color)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit req; int pl; int px; int py; int pc;
        bit cr;  int cl; bit tg; int tl;
    } stim_t;

    typedef struct {
        stim_t s; int ack; int en; int x; int y; int col; int vis;
    } vec_t;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: clear progress as a linear pixel index, not as a coordinate pair.
    bit       m_clear;
    int       m_k;
    int       m_layer;
    bit       m_rr;
    bit [3:0] m_vis;
    int       e_en, e_x, e_y, e_col;
    int       seen_ack;

    task automatic chk(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
        end
    endtask

    function automatic int vis_exp();
        bit [3:0] v;
        v = m_vis;
`ifdef CANVAS_CLEAR_HIDE_EN
        if (m_clear) v[m_layer] = 1'b0;
`endif
        return int'(v);
    endfunction

    function automatic stim_t mk(input bit req, input int pl, input int px, input int py, input int pc,
                                 input bit cr, input int cl, input bit tg, input int tl);
        stim_t s;
        s.req = req; s.pl = pl; s.px = px; s.py = py; s.pc = pc;
        s.cr = cr; s.cl = cl; s.tg = tg; s.tl = tl;
        return s;
    endfunction

    task automatic model_reset();
        m_clear = 1'b0; m_k = 0; m_layer = 0; m_rr = 1'b0; m_vis = 4'b1111;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; pen_req = 1'b0; clear_req = 1'b0; toggle_vis = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        chk("rst_wr_en", int'(wr_en), 0);
        chk("rst_wr_x", int'(wr_x), 0);
        chk("rst_wr_y", int'(wr_y), 0);
        chk("rst_wr_color", int'(wr_color), int'(NONE));
        chk("rst_busy", int'(clear_busy), 0);
        chk("rst_visible", int'(canvas_visible), 15);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One clock: drive, check combinational grant, clock, then check registered outputs.
    task automatic cycle(input stim_t s, output bit acked);
        bit pg, cg;
        @(negedge clk);
        pen_req = s.req; pen_layer = 2'(s.pl); pen_x = 3'(s.px); pen_y = 3'(s.py);
        pen_color = 4'(s.pc); clear_req = s.cr; clear_layer = 2'(s.cl);
        toggle_vis = s.tg; toggle_layer = 2'(s.tl);
        #1;
        pg = 1'b0; cg = 1'b0;
        if (!m_clear) begin
            pg = s.req;
        end else if (s.req && s.pl != m_layer) begin
            pg = !m_rr; cg = m_rr; m_rr = !m_rr;
        end else begin
            cg = 1'b1;
        end
        seen_ack = int'(pen_ack);
        chk("pen_ack", seen_ack, int'(pg));
        @(posedge clk);
        if (pg) begin
            e_en = 1 << s.pl; e_x = s.px; e_y = s.py; e_col = s.pc;
        end else if (cg) begin
            e_en = 1 << m_layer; e_x = m_k % W; e_y = m_k / W; e_col = int'(NONE);
        end else begin
            e_en = 0;
        end
        if (m_clear) begin
            if (cg) begin
                m_k++;
                if (m_k == W * H) m_clear = 1'b0;
            end
        end else if (s.cr) begin
            m_clear = 1'b1; m_layer = s.cl; m_k = 0;
        end
        if (s.tg) m_vis[s.tl] = ~m_vis[s.tl];
        #1;
        chk("wr_en", int'(wr_en), e_en);
        if (e_en != 0) begin
            chk("wr_x", int'(wr_x), e_x);
            chk("wr_y", int'(wr_y), e_y);
            chk("wr_color", int'(wr_color), e_col);
        end
        chk("clear_busy", int'(clear_busy), int'(m_clear));
        chk("canvas_visible", int'(canvas_visible), vis_exp());
        acked = pg;
    endtask

    initial begin
        vec_t  tbl[7];
        stim_t idle;
        stim_t s;
        bit    a;
        int    busy_cnt, en_cnt, acks, lands, p;
        bit    have;

        reset = 1'b1; pen_req = 1'b0; pen_layer = '0; pen_x = '0; pen_y = '0; pen_color = '0;
        clear_req = 1'b0; clear_layer = '0; toggle_vis = 1'b0; toggle_layer = '0;
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();

        tbl[0] = '{mk(1, 2, 3, 5, RED, 0, 0, 0, 0), 1, 4, 3, 5, RED, 15};
        tbl[1] = '{mk(0, 0, 0, 0, 0,   0, 0, 0, 0), 0, 0, 0, 0, 0, 15};
        tbl[2] = '{mk(0, 0, 0, 0, 0,   0, 0, 1, 3), 0, 0, 0, 0, 0, 7};
        tbl[3] = '{mk(0, 0, 0, 0, 0,   0, 0, 1, 3), 0, 0, 0, 0, 0, 15};
        tbl[4] = '{mk(1, 0, 7, 7, 5,   0, 0, 1, 1), 1, 1, 7, 7, 5, 13};
        tbl[5] = '{mk(0, 0, 0, 0, 0,   0, 0, 1, 1), 0, 0, 0, 0, 0, 15};
        tbl[6] = '{mk(1, 3, 1, 2, 9,   0, 0, 0, 0), 1, 8, 1, 2, 9, 15};

        do_reset();

        for (int i = 0; i < 7; i++) begin
            cycle(tbl[i].s, a);
            chk("tbl_ack", seen_ack, tbl[i].ack);
            chk("tbl_wr_en", int'(wr_en), tbl[i].en);
            if (tbl[i].en != 0) begin
                chk("tbl_wr_x", int'(wr_x), tbl[i].x);
                chk("tbl_wr_y", int'(wr_y), tbl[i].y);
                chk("tbl_wr_color", int'(wr_color), tbl[i].col);
            end
            chk("tbl_busy", int'(clear_busy), 0);
            chk("tbl_visible", int'(canvas_visible), tbl[i].vis);
        end

        // Uncontested clear of layer 0.
        do_reset();
        cycle(mk(0, 0, 0, 0, 0, 1, 0, 0, 0), a);
        busy_cnt = int'(clear_busy); en_cnt = 0;
        for (int i = 0; i < 80 && clear_busy; i++) begin
            cycle(idle, a);
            if (clear_busy) busy_cnt++;
            if (wr_en == 4'b0001) en_cnt++;
        end
        chk("clr0_busy_cycles", busy_cnt, 64);
        chk("clr0_writes", en_cnt, 64);
        chk("clr0_done", int'(clear_busy), 0);
        chk("clr0_visible_after", int'(canvas_visible), 15);

        // Clear layer 1 against a continuous pen stream to layer 3.
        do_reset();
        cycle(mk(0, 0, 0, 0, 0, 1, 1, 0, 0), a);
        busy_cnt = 1; acks = 0; lands = 0; p = 0;
        s = mk(1, 3, 0, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 300 && clear_busy; i++) begin
            s.px = p % W; s.py = (p / W) % H; s.pc = (p + 1) % 16;
            cycle(s, a);
            if (a) begin acks++; p++; end
            if (clear_busy) busy_cnt++;
            if (wr_en == 4'b1000) lands++;
        end
        chk("rr_busy_cycles", busy_cnt, 128);
        chk("rr_pen_acks", acks, 64);
        chk("rr_pen_lands", lands, acks);
        s.px = p % W; s.py = (p / W) % H; s.pc = (p + 1) % 16;
        cycle(s, a);
        chk("rr_tail_ack", int'(a), 1);

        // Clear layer 1 with the pen aimed at the same layer: pen waits for the whole sweep.
        do_reset();
        cycle(mk(0, 0, 0, 0, 0, 1, 1, 0, 0), a);
        acks = 0;
        s = mk(1, 1, 2, 6, 11, 0, 0, 0, 0);
        for (int i = 0; i < 100 && clear_busy; i++) begin
            cycle(s, a);
            if (a) acks++;
        end
        chk("stall_acks_during_clear", acks, 0);
        chk("stall_done", int'(clear_busy), 0);
        cycle(s, a);
        chk("stall_land_en", int'(wr_en), 2);
        chk("stall_land_color", int'(wr_color), 11);
        cycle(idle, a);

        // Pen and clear request together in IDLE, then reset mid-clear.
        cycle(mk(1, 2, 4, 4, 6, 1, 3, 0, 0), a);
        chk("same_cycle_ack", seen_ack, 1);
        chk("same_cycle_wr_en", int'(wr_en), 4);
        chk("same_cycle_busy", int'(clear_busy), 1);
        for (int i = 0; i < 10; i++) cycle(idle, a);
        do_reset();
        cycle(idle, a);
        chk("post_reset_wr_en", int'(wr_en), 0);

        // Random traffic; pen fields held until accepted.
        have = 1'b0;
        s = idle;
        for (int i = 0; i < 1500; i++) begin
            if (!have && $urandom_range(0, 9) < 6) begin
                have = 1'b1;
                s.req = 1'b1;
                s.pl = int'($urandom_range(0, 3));
                s.px = int'($urandom_range(0, W - 1));
                s.py = int'($urandom_range(0, H - 1));
                s.pc = int'($urandom_range(0, 15));
            end
            s.cr = ($urandom_range(0, 49) == 0);
            s.cl = int'($urandom_range(0, 3));
            s.tg = ($urandom_range(0, 7) == 0);
            s.tl = int'($urandom_range(0, 3));
            cycle(s, a);
            if (a) begin
                have = 1'b0;
                s.req = 1'b0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
